// File: rtl/imem_pkg.sv
// Shared types and default sizes for the loadable instruction memory.
// Contents: FSM state encoding, default word width and address width.
// Imported by imem_ram and imem_prog.
package imem_pkg;

  localparam int IMEM_N  = 32;
  localparam int IMEM_AW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-clock instruction storage: one write port, one registered read port.
// Ports: clk; we/waddr/wdata write side; re/raddr read request, rdata valid
// the cycle after re and held until the next read. Storage is never reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter int N  = IMEM_N,
  parameter int AW = IMEM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  localparam int DEPTH = 1 << AW;

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // Read register only moves on a request, so it holds the last response.
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory with IDLE/LOAD/RUN control and range-checked fetch.
// Ports: clk/reset (sync, active-low); prog_* loader port; f_req/f_addr fetch
// request, f_ready accept; f_valid/f_q/f_err response one cycle after accept;
// words_loaded program length; state_o debug state.
module imem_prog
  import imem_pkg::*;
#(
  parameter int           N         = IMEM_N,
  parameter int           AW        = IMEM_AW,
  parameter logic [N-1:0] FILL_WORD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [N-1:0]  prog_data,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ready,
  output logic          f_valid,
  output logic [N-1:0]  f_q,
  output logic          f_err,
  output logic [AW:0]   words_loaded,
  output logic [1:0]    state_o
);

  imem_state_t  state_q, state_d;
  logic [AW:0]  wl_q, wl_d;
  logic [AW:0]  wr_end;
  logic         f_ready_q;
  logic         f_valid_q;
  logic         f_err_q;
  logic         seen_q;    // a response has been issued since reset
  logic         accept;
  logic         ld_wr;
  logic [N-1:0] ram_rdata;

  assign accept = f_req && (state_q == RUN);
  assign ld_wr  = prog_we && (state_q == LOAD);
  assign wr_end = {1'b0, prog_addr} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    wl_d = wl_q;
    if (ld_wr && (wr_end > wl_q)) begin
      wl_d = wr_end;
    end
  end

  // The LOAD exit looks at wl_d so a final write issued with prog_en
  // already low still counts toward entering RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (prog_en)  state_d = LOAD;
      LOAD:    if (!prog_en) state_d = (wl_d != '0) ? RUN : IDLE;
      RUN:     if (prog_en)  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      f_ready_q <= 1'b0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      seen_q    <= 1'b0;
      wl_q      <= '0;
    end else begin
      state_q   <= state_d;
      f_ready_q <= (state_d == RUN);
      wl_q      <= wl_d;
      f_valid_q <= accept;
      if (accept) begin
        // Range check uses the length as it stands at accept time.
        f_err_q <= ({1'b0, f_addr} >= wl_q);
        seen_q  <= 1'b1;
      end
    end
  end

  imem_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ld_wr && reset),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (accept && reset),
    .raddr (f_addr),
    .rdata (ram_rdata)
  );

  assign f_ready      = f_ready_q;
  assign f_valid      = f_valid_q;
  assign f_err        = f_err_q;
  // Read register is unreset storage, so report zero until the first response.
  assign f_q          = !seen_q ? '0 : (f_err_q ? FILL_WORD : ram_rdata);
  assign words_loaded = wl_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_imem_prog.sv
module tb_imem_prog;

  localparam int          N    = 32;
  localparam int          AW   = 8;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_en, prog_we;
  logic [AW-1:0] prog_addr;
  logic [N-1:0]  prog_data;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ready, f_valid, f_err;
  logic [N-1:0]  f_q;
  logic [AW:0]   words_loaded;
  logic [1:0]    state_o;

  imem_prog #(.N(N), .AW(AW), .FILL_WORD(FILL)) dut (
    .clk          (clk),
    .reset        (reset),
    .prog_en      (prog_en),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .f_req        (f_req),
    .f_addr       (f_addr),
    .f_ready      (f_ready),
    .f_valid      (f_valid),
    .f_q          (f_q),
    .f_err        (f_err),
    .words_loaded (words_loaded),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        err;
    bit          chk_q;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   q;
    logic          err;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every f_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (f_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got f_valid=1 f_q=%0h expected no response", f_q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_q) check("resp_q", f_q, e.q);
        check("resp_err", {31'b0, f_err}, {31'b0, e.err});
      end
    end
  end

  task automatic ld_write(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  // One-cycle request in RUN; expectation queued as the request is driven.
  task automatic fetch(input logic [AW-1:0] a, input logic [31:0] q, input logic err, input bit chk_q);
    exp_t e;
    e.q = q; e.err = err; e.chk_q = chk_q;
    sb.push_back(e);
    f_req  = 1'b1;
    f_addr = a;
    step();
    f_req  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 8) begin
      step();
      k++;
    end
    step();
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{addr: 8'd0, q: 32'hf8000001, err: 1'b0};
    tbl[1] = '{addr: 8'd1, q: 32'hf8008002, err: 1'b0};
    tbl[2] = '{addr: 8'd2, q: 32'hb400001f, err: 1'b0};
    tbl[3] = '{addr: 8'd3, q: FILL,         err: 1'b1};

    reset = 1'b0; prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    f_req = 1'b0; f_addr = '0;
    repeat (3) step();
    check("rst_state", {30'b0, state_o}, 32'd0);
    check("rst_valid", {31'b0, f_valid}, 32'd0);
    check("rst_q",     f_q, 32'd0);
    check("rst_err",   {31'b0, f_err}, 32'd0);
    check("rst_wl",    {23'b0, words_loaded}, 32'd0);
    reset = 1'b1;

    // 1: requests in IDLE are never accepted
    f_req = 1'b1; f_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ready", {31'b0, f_ready}, 32'd0);
    end
    f_req = 1'b0;
    step();
    check("idle_state", {30'b0, state_o}, 32'd0);
    check("idle_wl", {23'b0, words_loaded}, 32'd0);

    // 2: load three words
    prog_en = 1'b1;
    step();
    check("load_state", {30'b0, state_o}, 32'd1);
    ld_write(8'd0, 32'hf8000001);
    ld_write(8'd1, 32'hf8008002);
    ld_write(8'd2, 32'hb400001f);
    prog_en = 1'b0;
    step();
    check("run_wl", {23'b0, words_loaded}, 32'd3);
    check("run_state", {30'b0, state_o}, 32'd2);
    check("run_ready", {31'b0, f_ready}, 32'd1);
    fetch(8'd1, 32'hf8008002, 1'b0, 1'b1);
    wait_drain("drain_single");

    // 3: back-to-back from the table
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.q = tbl[i].q; e.err = tbl[i].err; e.chk_q = 1'b1;
      sb.push_back(e);
      f_req = 1'b1; f_addr = tbl[i].addr;
      step();
    end
    f_req = 1'b0;
    wait_drain("drain_b2b");

    // 4: top address, written as the last word with prog_en already low
    prog_en = 1'b1;
    step();
    prog_en = 1'b0;
    ld_write(8'd255, 32'h0000_00ff);
    check("wl_max", {23'b0, words_loaded}, 32'd256);
    check("wl_max_state", {30'b0, state_o}, 32'd2);
    fetch(8'd200, 32'd0, 1'b0, 1'b0);
    fetch(8'd255, 32'h0000_00ff, 1'b0, 1'b1);
    fetch(8'd2, 32'hb400001f, 1'b0, 1'b1);
    wait_drain("drain_top");

    // 5: prog_en rises together with an accepted fetch
    begin
      exp_t e;
      e.q = 32'hf8000001; e.err = 1'b0; e.chk_q = 1'b1;
      sb.push_back(e);
    end
    f_req = 1'b1; f_addr = 8'd0; prog_en = 1'b1;
    step();
    check("race_state", {30'b0, state_o}, 32'd1);
    check("race_ready", {31'b0, f_ready}, 32'd0);
    ld_write(8'd0, 32'h1111_1111);
    step();
    f_req = 1'b0; prog_en = 1'b0;
    step();
    check("race_run", {30'b0, state_o}, 32'd2);
    fetch(8'd0, 32'h1111_1111, 1'b0, 1'b1);
    wait_drain("drain_race");

    // 6: reset in the middle of a load
    prog_en = 1'b1;
    step();
    ld_write(8'd5, 32'h5555_5555);
    reset = 1'b0;
    step();
    check("mid_rst_state", {30'b0, state_o}, 32'd0);
    check("mid_rst_wl", {23'b0, words_loaded}, 32'd0);
    reset = 1'b1; prog_en = 1'b0;
    step();
    check("post_rst_state", {30'b0, state_o}, 32'd0);
    prog_en = 1'b1;
    step();
    ld_write(8'd0, 32'h2222_2222);
    prog_en = 1'b0;
    step();
    check("reload_wl", {23'b0, words_loaded}, 32'd1);
    fetch(8'd5, FILL, 1'b1, 1'b1);
    fetch(8'd0, 32'h2222_2222, 1'b0, 1'b1);
    wait_drain("drain_reload");

    // Fetch accepted in a reset cycle gets no response; outputs return to zero.
    f_req = 1'b1; f_addr = 8'd0; reset = 1'b0;
    step();
    f_req = 1'b0; reset = 1'b1;
    repeat (3) step();
    check("abort_q", f_q, 32'd0);
    check("abort_err", {31'b0, f_err}, 32'd0);
    check("abort_state", {30'b0, state_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
Parametrised, loadable instruction memory. It succeeds the fixed-content combinational instruction ROM of the single-cycle LEGv8 datapath.
- Contents are written through a programming port while the core is held off.
- Instruction fetch uses a registered request/valid handshake with one-cycle read latency.
- Fetches beyond the loaded program are flagged instead of silently returning zero.
- Sits between the fetch stage (PC) and the off-core program loader.

Parameters:
N, 32, instruction word width in bits
AW, 8, address width in words; depth = 2**AW
FILL_WORD, 32'h00000000, value returned on f_q for out-of-range fetches (width N)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
prog_en  input  1  loader owns the memory while high
prog_we  input  1  write strobe, honoured only in LOAD
prog_addr  input  AW  word address for write
prog_data  input  N  word to write
f_req  input  1  fetch request
f_addr  input  AW  word address to fetch
f_ready  output  1  fetch request can be accepted this cycle
f_valid  output  1  f_q/f_err valid this cycle
f_q  output  N  fetched instruction
f_err  output  1  fetched address was at or above words_loaded
words_loaded  output  AW+1  program length: highest written address + 1
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; f_valid=0; f_q=0; f_err=0; words_loaded=0.
  - Array contents are not cleared.
  - Reset applied mid-LOAD or mid-fetch aborts the operation; no response is issued for a fetch accepted in that cycle.
- FSM states:
  - IDLE: f_ready=0. On prog_en=1, go to LOAD next cycle.
  - LOAD: f_ready=0.
    - Each cycle with prog_we=1 writes prog_data to mem[prog_addr].
    - On each such write, words_loaded <= max(words_loaded, prog_addr+1), computed in AW+1 bits.
  - LOAD -> RUN when prog_en=0 and words_loaded!=0.
  - LOAD -> IDLE when prog_en=0 and words_loaded==0.
  - RUN: f_ready=1. On prog_en=1, go to LOAD next cycle; words_loaded keeps its value (reload may extend it).
  - Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- prog_we is ignored in IDLE and RUN. The write is honoured in LOAD even if prog_en=0 that same cycle (last word of a burst).
- The write in the IDLE->LOAD transition cycle is ignored; the loader must wait one cycle after raising prog_en.
- Fetch:
  - A request is accepted when f_req && f_ready at a rising edge.
  - Exactly one cycle later: f_valid=1.
  - If f_addr < words_loaded: f_q=mem[f_addr], f_err=0.
  - Otherwise: f_q=FILL_WORD, f_err=1.
  - f_valid is high for a single cycle per accepted request; there is no backpressure.
  - Back-to-back requests give one response per cycle, in order.
  - When f_valid=0, f_q and f_err hold their last values.
- Simultaneous prog_en rise and accepted fetch in RUN: the fetch is still answered next cycle (state now LOAD), using the pre-load words_loaded and array contents.
- words_loaded boundary: writing address 2**AW-1 gives words_loaded=2**AW. The AW+1-bit width prevents wrap, so all addresses then fetch without f_err.
- Read array: synchronous read, registered output. No read/write collision is possible because writes occur only in LOAD and fetches are accepted only in RUN.

Decomposition:
- Package imem_pkg holds:
  - typedef enum logic [1:0] {IDLE=2'b00, LOAD=2'b01, RUN=2'b10} imem_state_t;
  - default constants IMEM_N=32, IMEM_AW=8.
- Sub-module imem_ram: single-clock array with one write port and one registered read port, parameters N and AW, no reset on storage.
- imem_prog contains the FSM, the words_loaded tracker, the range check and the response registers.

Test Plan:
1. Reset, then f_req=1 for 3 cycles -> f_ready=0, f_valid never asserts, words_loaded=0, state_o=IDLE.
2. Load: raise prog_en, then write 0xf8000001 @0, 0xf8008002 @1, 0xb400001f @2, then drop prog_en.
   -> words_loaded=3, state_o=RUN.
   -> Fetch addr 1: f_valid one cycle later with f_q=0xf8008002, f_err=0.
3. Back-to-back fetches 0,1,2,3 -> four consecutive f_valid cycles: f_q=0xf8000001, 0xf8008002, 0xb400001f, FILL_WORD; f_err=1 only on the fourth.
4. Write address 255 only (AW=8) -> words_loaded=256; fetch 200 -> f_err=0.
5. prog_en rises in the same cycle a fetch of addr 0 is accepted in RUN -> response next cycle with old data; subsequent f_req ignored until prog_en drops.
6. Assert reset mid-LOAD after writing @5 -> state_o=IDLE, words_loaded=0.
   -> Reload writing only @0 and enter RUN; fetch 5 -> f_err=1, f_q=FILL_WORD.
